// File: rtl/adder_measure_pkg.sv
// Shared types and helpers for the ring-oscillator adder delay measurement sequencer.
package adder_measure_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_RUN,
      S_DRAIN,
      S_CAPTURE
   } state_t;

   localparam int DRAIN_CYCLES = 2;
   localparam int MAX_W        = 256;

   // Active-low one-hot; callers truncate to their own operand width.
   function automatic logic [MAX_W-1:0] onehot_b(input logic [7:0] idx);
      return ~(MAX_W'(1) << idx);
   endfunction

endpackage

// File: rtl/adder_measure_ctrl_if.sv
// Logic-analyser command/result bundle between the register block and the sequencer.
interface adder_measure_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32,
   parameter int SEL_W = $clog2(WIDTH)
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [SEL_W-1:0] ring_sel;
   logic [SEL_W-1:0] out_sel;
   logic [15:0]      window;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] result_count;
   logic [WIDTH-1:0] result_sum;

   modport master (
      output start, abort, a_in, b_in, ring_sel, out_sel, window,
      input  busy, done, aborted, result_count, result_sum
   );

   modport slave (
      input  start, abort, a_in, b_in, ring_sel, out_sel, window,
      output busy, done, aborted, result_count, result_sum
   );
endinterface

// File: rtl/adder_measure_ctrl.sv
// Sequences one ring-oscillator delay measurement: load operands, settle, count for a
// programmed window, drain the counter synchroniser, then capture count and sum.
module adder_measure_ctrl
   import adder_measure_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int CNT_W         = 32,
   parameter int SETTLE_CYCLES = 4,
   parameter int SEL_W         = $clog2(WIDTH)
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   adder_measure_ctrl_if.slave la,
   output logic [WIDTH-1:0] a_input,
   output logic [WIDTH-1:0] b_input,
   output logic [WIDTH-1:0] a_input_ring_bit_b,
   output logic [WIDTH-1:0] s_output_bit_b,
   output logic             ring_en,
   output logic             cnt_clear,
   input  logic [CNT_W-1:0] ring_count,
   input  logic [WIDTH-1:0] sum
);

   state_t      state, nxt;
   logic [15:0] cnt;
   logic [15:0] win_q;
   logic        accept;
   logic        abort_busy;
   logic        aborted_q;
   logic [CNT_W-1:0] res_cnt_q;
   logic [WIDTH-1:0] res_sum_q;

   assign accept     = (state == S_IDLE) && la.start && !la.abort;
   assign abort_busy = (state != S_IDLE) && la.abort;

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:    if (accept) nxt = S_LOAD;
         S_LOAD:    nxt = S_SETTLE;
         S_SETTLE:  if (cnt == 16'd0) nxt = (win_q == 16'd0) ? S_DRAIN : S_RUN;
         S_RUN:     if (cnt == 16'd0) nxt = S_DRAIN;
         S_DRAIN:   if (cnt == 16'd0) nxt = S_CAPTURE;
         S_CAPTURE: nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
      if (abort_busy) nxt = S_IDLE;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= nxt;
   end

   // One down-counter times SETTLE, RUN and DRAIN; reloaded on each phase entry.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt <= '0;
      end else if (nxt != state) begin
         unique case (nxt)
            S_SETTLE: cnt <= 16'(SETTLE_CYCLES - 1);
            S_RUN:    cnt <= win_q - 16'd1;
            S_DRAIN:  cnt <= 16'(DRAIN_CYCLES - 1);
            default:  cnt <= cnt;
         endcase
      end else if (cnt != 16'd0) begin
         cnt <= cnt - 16'd1;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         a_input            <= '0;
         b_input            <= '0;
         win_q              <= '0;
         a_input_ring_bit_b <= '1;
         s_output_bit_b     <= '1;
         aborted_q          <= 1'b0;
         res_cnt_q          <= '0;
         res_sum_q          <= '0;
      end else begin
         aborted_q <= abort_busy;
         if (accept) begin
            a_input            <= la.a_in;
            b_input            <= la.b_in;
            win_q              <= la.window;
            a_input_ring_bit_b <= WIDTH'(onehot_b(8'(la.ring_sel)));
            s_output_bit_b     <= WIDTH'(onehot_b(8'(la.out_sel)));
         end else if ((state != S_IDLE) && (nxt == S_IDLE)) begin
            a_input_ring_bit_b <= '1;
            s_output_bit_b     <= '1;
         end
         // Results land on CAPTURE entry so they are valid while done is high.
         if ((state == S_DRAIN) && (nxt == S_CAPTURE)) begin
            res_cnt_q <= ring_count;
            res_sum_q <= sum;
         end
      end
   end

   assign la.busy         = (state != S_IDLE);
   assign la.done         = (state == S_CAPTURE);
   assign la.aborted      = aborted_q;
   assign la.result_count = res_cnt_q;
   assign la.result_sum   = res_sum_q;
   assign ring_en         = (state == S_RUN);
   assign cnt_clear       = (state == S_LOAD);

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Scoreboard bench for adder_measure_ctrl with a stub ring counter and stub adder.
module tb_adder_measure_ctrl;

   localparam int W      = 32;
   localparam int CW     = 32;
   localparam int SETTLE = 4;
   localparam int SW     = 5;
   localparam int STEP   = 466;   // 10 RUN cycles * 466 = 0x1234

   typedef struct {
      logic [31:0] cnt;
      logic [31:0] sum;
      logic [31:0] asel;
      logic [31:0] ssel;
      int          ren;
      int          done_edge;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  a_input, b_input, a_sel_b, s_sel_b, sum;
   logic          ring_en, cnt_clear;
   logic [CW-1:0] ring_count;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0, n_fail = 0;
   int   edge_cnt = 0, ren_cnt = 0, done_cnt = 0;

   adder_measure_ctrl_if #(.WIDTH(W), .CNT_W(CW), .SEL_W(SW)) la();

   adder_measure_ctrl #(.WIDTH(W), .CNT_W(CW), .SETTLE_CYCLES(SETTLE), .SEL_W(SW)) dut (
      .wb_clk_i           (clk),
      .wb_rst_i           (rst),
      .la                 (la),
      .a_input            (a_input),
      .b_input            (b_input),
      .a_input_ring_bit_b (a_sel_b),
      .s_output_bit_b     (s_sel_b),
      .ring_en            (ring_en),
      .cnt_clear          (cnt_clear),
      .ring_count         (ring_count),
      .sum                (sum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   assign sum = a_input + b_input;

   always @(posedge clk or posedge rst) begin
      if (rst)            ring_count <= '0;
      else if (cnt_clear) ring_count <= '0;
      else if (ring_en)   ring_count <= ring_count + CW'(STEP);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every done.
   always @(negedge clk) begin
      if (!rst) begin
         if (cnt_clear) ren_cnt = 0;
         if (ring_en) begin
            ren_cnt++;
            if (ren_cnt == 1 && sb.size() > 0) begin
               chk("run_a_sel", a_sel_b, sb[0].asel);
               chk("run_s_sel", s_sel_b, sb[0].ssel);
            end
         end
         if (la.done) begin
            done_cnt++;
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
               mon_e = sb.pop_front();
               chk("result_count", la.result_count, mon_e.cnt);
               chk("result_sum", la.result_sum, mon_e.sum);
               chk("ring_en_cycles", ren_cnt, mon_e.ren);
               chk("done_edge", edge_cnt, mon_e.done_edge);
            end
         end
      end
   end

   function automatic exp_t mk_exp(input logic [31:0] a, b, input logic [4:0] rs, os,
                                   input logic [15:0] w, input int acc_edge);
      exp_t e;
      logic [31:0] one;
      one         = 32'd1;
      e.cnt       = 32'(STEP * int'(w));
      e.sum       = a + b;
      e.asel      = ~(one << rs);
      e.ssel      = ~(one << os);
      e.ren       = int'(w);
      e.done_edge = acc_edge + 1 + SETTLE + int'(w) + 2;
      return e;
   endfunction

   // Called at a negedge; start is sampled at the following posedge.
   task automatic launch(input logic [31:0] a, b, input logic [4:0] rs, os,
                         input logic [15:0] w, input bit exp_done);
      la.a_in = a; la.b_in = b; la.ring_sel = rs; la.out_sel = os; la.window = w;
      la.start = 1'b1;
      if (exp_done) sb.push_back(mk_exp(a, b, rs, os, w, edge_cnt + 1));
      @(negedge clk);
      la.start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("timeout", sb.size(), 0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int n, d0, acc;
      la.start = 0; la.abort = 0; la.a_in = '0; la.b_in = '0;
      la.ring_sel = '0; la.out_sel = '0; la.window = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", la.busy, 0);
      chk("rst_ring_en", ring_en, 0);
      chk("rst_a_sel", a_sel_b, 32'hFFFF_FFFF);
      chk("rst_s_sel", s_sel_b, 32'hFFFF_FFFF);
      chk("rst_result", {la.result_count, la.result_sum}, 64'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_a_sel", a_sel_b, 32'hFFFF_FFFF);
      chk("idle_s_sel", s_sel_b, 32'hFFFF_FFFF);
      chk("idle_busy", la.busy, 0);
      chk("idle_no_done", done_cnt, 0);

      launch(32'd3, 32'd5, 5'd4, 5'd7, 16'd10, 1);
      chk("load_busy", la.busy, 1);
      chk("load_cnt_clear", cnt_clear, 1);
      wait_idle();
      chk("after_a_sel", a_sel_b, 32'hFFFF_FFFF);
      chk("operands_hold", {a_input, b_input}, {32'd3, 32'd5});

      launch(32'd100, 32'd23, 5'd0, 5'd31, 16'd0, 1);
      wait_idle();

      // Abort on the third RUN cycle.
      launch(32'd7, 32'd9, 5'd2, 5'd3, 16'd10, 0);
      n = 0;
      for (int i = 0; i < 50 && n < 3; i++) begin
         @(negedge clk);
         if (ring_en) n++;
      end
      chk("abort_reach_run", n, 3);
      la.abort = 1'b1;
      @(negedge clk);
      la.abort = 1'b0;
      chk("abort_ring_en", ring_en, 0);
      chk("abort_pulse", la.aborted, 1);
      chk("abort_busy", la.busy, 0);
      chk("abort_a_sel", a_sel_b, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("abort_pulse_end", la.aborted, 0);
      chk("abort_results", {la.result_count, la.result_sum}, {32'd0, 32'd123});

      // Start+abort together in IDLE is refused.
      la.start = 1'b1; la.abort = 1'b1;
      @(negedge clk);
      la.start = 1'b0; la.abort = 1'b0;
      chk("start_abort_idle", la.busy, 0);

      // Extra start while busy is dropped.
      d0 = done_cnt;
      launch(32'h1000, 32'h0234, 5'd10, 5'd11, 16'd5, 1);
      repeat (2) @(negedge clk);
      la.a_in = 32'd99; la.start = 1'b1;
      @(negedge clk);
      la.start = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);
      chk("one_done", done_cnt - d0, 1);

      // start held high: back-to-back runs with one IDLE cycle between.
      la.a_in = 32'hFFFF_FFFF; la.b_in = 32'd2; la.ring_sel = 5'd31; la.out_sel = 5'd0;
      la.window = 16'd3; la.start = 1'b1;
      acc = edge_cnt + 1;
      sb.push_back(mk_exp(32'hFFFF_FFFF, 32'd2, 5'd31, 5'd0, 16'd3, acc));
      sb.push_back(mk_exp(32'hFFFF_FFFF, 32'd2, 5'd31, 5'd0, 16'd3, acc + 1 + SETTLE + 3 + 2 + 2));
      n = 0;
      for (int i = 0; i < 50 && !la.done; i++) @(negedge clk);
      chk("b2b_first_done", la.done, 1);
      @(negedge clk);
      chk("b2b_gap_idle", la.busy, 0);
      @(negedge clk);
      chk("b2b_restart", la.busy, 1);
      la.start = 1'b0;
      wait_idle();

      // Asynchronous reset during SETTLE.
      launch(32'd11, 32'd22, 5'd1, 5'd2, 16'd10, 0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", la.busy, 0);
      chk("arst_sel", {a_sel_b, s_sel_b}, {64{1'b1}});
      chk("arst_operands", {a_input, b_input}, 64'h0);
      chk("arst_results", {la.result_count, la.result_sum}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_arst_idle", la.busy, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/adder_measure_ctrl.md
# adder_measure_ctrl

Sequencer for the instrumented adder's ring-oscillator delay measurement. It accepts one measurement command from logic-analyser registers and drives the adder operands and active-low bit-select vectors. It opens a counting window of a programmed length, then captures the ring count and adder sum. It sits between the LA register interface and the instrumented adder inside the wrapped project.

## Interface
- WIDTH, 32, adder operand width
- CNT_W, 32, ring counter width
- SETTLE_CYCLES, 4, operand settle cycles before the window opens (≥1)
- SEL_W, $clog2(WIDTH), bit-select index width

Ports:
- wb_clk_i  in  1  the single clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start  in  1  level; sampled only in IDLE
- abort  in  1  level; returns the block to IDLE from any busy state
- a_in, b_in  in  WIDTH  operands, latched on accepted start
- ring_sel  in  SEL_W  adder bit placed in the ring
- out_sel  in  SEL_W  sum bit tapped for the ring
- window  in  16  RUN length in clocks
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in CAPTURE
- aborted  out  1  one-cycle pulse after an abort
- result_count  out  CNT_W  captured ring count, held until the next CAPTURE
- result_sum  out  WIDTH  captured adder sum, held
- a_input, b_input  out  WIDTH  operands to the adder
- a_input_ring_bit_b  out  WIDTH  active-low one-hot ring-bit select
- s_output_bit_b  out  WIDTH  active-low one-hot output-bit select
- ring_en  out  1  ring oscillator enable
- cnt_clear  out  1  ring counter synchronous clear
- ring_count  in  CNT_W  counter value, already synchronised to wb_clk_i
- sum  in  WIDTH  adder sum

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DRAIN, CAPTURE.
- IDLE: if start=1 and abort=0, latch a_in, b_in, ring_sel, out_sel and window, then go to LOAD. If start stays high after done, a new run begins.
- LOAD (1 cycle): drive the operands; cnt_clear=1; drive the one-hot select bits low for the latched indices.
- SETTLE (SETTLE_CYCLES cycles): hold, then go to RUN. Go straight to DRAIN if the latched window=0.
- RUN (window cycles): ring_en=1; 16-bit down-counter loaded from window.
- DRAIN (2 cycles): ring_en=0; lets the synchroniser path in the counter settle.
- CAPTURE (1 cycle): register result_count←ring_count and result_sum←sum; done=1; return to IDLE.
- abort=1 in any busy state: next state IDLE; ring_en=0 immediately, since it is decoded from state; aborted pulses for 1 cycle; results are not updated; done does not pulse.
- Simultaneous start and abort in IDLE: abort wins and the command is not accepted.
- start while busy: ignored, not queued.
- Select vectors are all-ones in IDLE and after CAPTURE/abort, so the ring is fully open. Operands hold their last value.

## Timing
- Reset values:
  - state=IDLE
  - busy=0, done=0, aborted=0, ring_en=0, cnt_clear=0
  - a_input=0, b_input=0
  - a_input_ring_bit_b and s_output_bit_b all ones
  - result_count=0, result_sum=0
- Latency: with start sampled at edge 0, done is high in the cycle after edge 1+SETTLE_CYCLES+window+2.
  - Default, window=10: done follows edge 17.
  - window=0: done follows edge 7, with result_count as cleared.
- ring_en is high for exactly window consecutive cycles.
- Every output is registered or decoded from state only. No combinational path from inputs to outputs.
- Reset mid-run: immediate return to IDLE, all outputs at reset values.

## Structure
- Shared package adder_measure_pkg holds:
  - state enum
  - DRAIN_CYCLES=2
  - a one-hot active-low decode function
- A single flat module. The 16-bit window counter stays inline and is not a sub-module.

## Test plan
- Reset, then idle 5 cycles: both select vectors 0xFFFFFFFF, busy=0, no done.
- start with a=3, b=5, ring_sel=4, out_sel=7, window=10; stub counter returns 0x1234:
  - a_input_ring_bit_b=0xFFFFFFEF and s_output_bit_b=0xFFFFFF7F during the run
  - ring_en high for exactly 10 cycles
  - done after edge 17
  - result_count=0x1234, result_sum=8
- window=0: ring_en never high, done after edge 7.
- abort asserted on the 3rd RUN cycle: ring_en low next cycle, aborted pulse, no done, results unchanged from the previous run.
- start pulsed again while busy: ignored, exactly one done. start held high: back-to-back runs with 1 IDLE cycle between.
- wb_rst_i asserted mid-SETTLE asynchronously: outputs return to reset values before the next clock edge.
